ahb_slave_if_multi: RTL

//  Parametrised AHB-Lite slave front-end. Captures address/control in the address phase and decodes
//  the address into NUM_SLV one-hot backend selects. Drives a valid/ready backend handshake in the

---
 rtl/ahb_slave_if_multi.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ahb_slave_if_multi.sv
// AHB-Lite slave front-end: decodes the address into one-hot backend regions, runs a valid/ready
// backend handshake in the data phase and returns two-cycle ERROR responses for bad or timed-out transfers.
module ahb_slave_if_multi #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLV    = 4,
  parameter int REGION_LSB = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               BE_VALID,
  output logic [NUM_SLV-1:0] BE_SEL,
  output logic               BE_WRITE,
  output logic [ADDR_W-1:0]  BE_ADDR,
  output logic [2:0]         BE_SIZE,
  output logic [DATA_W-1:0]  BE_WDATA,
  input  logic               BE_READY,
  input  logic [DATA_W-1:0]  BE_RDATA
);

  localparam int SW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  localparam int CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic [NUM_SLV-1:0]  sel_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [SW-1:0]       region;
  logic [ADDR_W-1:0]   hi_bits;
  logic [NUM_SLV-1:0]  onehot;
  logic                cap_req, cap_bad, cap_en, rd_upd;

  // Address-phase decode
  assign region  = HADDR[REGION_LSB +: SW];
  assign hi_bits = HADDR >> (REGION_LSB + SW);
  assign onehot  = NUM_SLV'(1) << region;
  assign cap_req = HSEL & HREADY & HTRANS[1];
  assign cap_bad = (hi_bits != '0) || (int'(region) >= NUM_SLV) || (HSIZE > 3'(MAX_SIZE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_en    = 1'b0;
    rd_upd    = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    BE_VALID  = 1'b0;
    unique case (state_q)
      S_IDLE: cap_en = 1'b1;
      S_ACCESS: begin
        BE_VALID  = 1'b1;
        HREADYOUT = BE_READY;
        if (BE_READY) begin
          cap_en = 1'b1;
          rd_upd = ~write_q;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP  = 1'b1;
        cap_en = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Any cycle that ends a data phase may also accept the next address phase
    if (cap_en) begin
      state_d = cap_req ? (cap_bad ? S_ERR1 : S_ACCESS) : S_IDLE;
      if (cap_req && !cap_bad) cnt_d = '0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_en && cap_req) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        sel_q   <= cap_bad ? '0 : onehot;
      end
      if (rd_upd) rdata_q <= BE_RDATA;
    end
  end

  assign BE_SEL   = BE_VALID ? sel_q : '0;
  assign BE_WRITE = write_q;
  assign BE_ADDR  = addr_q;
  assign BE_SIZE  = size_q;
  assign BE_WDATA = HWDATA;
  // Completing read data is forwarded in the same cycle it is registered
  assign HRDATA   = rd_upd ? BE_RDATA : rdata_q;

endmodule
